mul_unit: RTL and testbench
===========================

// Module: mul_unit
// PURPOSE
//  Iterative multi-cycle multiplier for RV32M MUL/MULH/MULHSU/MULHU, in the EX stage.
//  It is the responder to the ID-stage controller's MUL stall state.
//  The controller raises start with the decoded operands and holds the pipe until done pulses.
//  It then forwards result to the EX/MEM register.
// PARAMETERS
//  XLEN            32  operand/result width
//  BITS_PER_CYCLE  8   multiplier bits retired per CALC cycle; must divide XLEN (ITER = XLEN/BITS_PER_CYCLE)
// PORTS
//  clk       in   1     single clock; all state updates on posedge clk
//  rst       in   1     synchronous, active-high reset
//  start     in   1     request; sampled only in IDLE
//  funct3    in   3     [1:0] selects op: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; [2] ignored
//  rs1_data  in   XLEN  multiplicand (signed for MUL/MULH/MULHSU)
//  rs2_data  in   XLEN  multiplier (signed for MUL/MULH only)
//  flush     in   1     abort in-flight op (branch/trap)
//  busy      out  1     high in CALC, FIX and DONE
//  done      out  1     1-cycle pulse; result valid this cycle
//  result    out  XLEN  product half per funct3; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; done=0; result=0; internal regs cleared. Takes priority over all inputs.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: start=1 && flush=0 -> latch operands, op and sign flags; cnt=0; go to CALC. Otherwise stay.
//  - CALC: acc += mag_a * mag_b[slice]. Slice is BITS_PER_CYCLE wide, taken LSB-first, shifted into position.
//    cnt++; at cnt==ITER-1 go to FIX.
//  - FIX: if neg, acc = ~acc + 1 (2*XLEN bits). result = (op==MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN]. Go to DONE.
//  - DONE: done=1 for exactly this cycle; go to IDLE.
//  Latency: start sampled at cycle 0 -> done=1 in cycle ITER+2 (6 for defaults). Fixed; no zero-operand early exit.
//  Operand conversion at accept:
//  - sign_a = rs1[XLEN-1] & (op!=MULHU); sign_b = rs2[XLEN-1] & (op==MUL||op==MULH).
//  - mag = sign ? -x : x, held as XLEN-bit unsigned. -2^(XLEN-1) maps to 2^(XLEN-1) with no overflow.
//  - neg = sign_a ^ sign_b. acc is 2*XLEN bits unsigned; no carry-out possible.
//  start while busy: ignored, no queuing. The requester must wait for done.
//  flush in CALC/FIX: next state IDLE; no done; result keeps its previous value.
//  flush in DONE: done still pulses this cycle (already committed); next state IDLE.
//  flush with start in IDLE: start rejected.
//  rst mid-operation: IDLE next cycle; done never asserted for the aborted op.
//  done and busy are both high in DONE. busy falls the cycle after done.
// STRUCTURE
//  Shared defines.v: FUNCT3_MUL/MULH/MULHSU/MULHU encodings and state encodings MU_IDLE/MU_CALC/MU_FIX/MU_DONE (2-bit).
//  One sub-module: mul_operand_conv (combinational).
//  - Inputs: rs1, rs2, op. Outputs: mag_a, mag_b, neg.
//  - Instantiated once, ahead of the operand latch.
//  Remainder (FSM, counter, accumulator, final negate/select) stays in mul_unit.
// TESTING
//  1. MUL 7 x 0xFFFFFFFD (-3): start at cycle 0 -> done=1 at cycle 6 only, result=0xFFFFFFEB; busy high cycles 1-6.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL of the same operands -> 0x00000000.
//  3. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
//  4. Second start pulsed at cycles 2-4 during an op -> ignored; exactly one done; result from the first op.
//  5. flush at cycle 3 of an op -> IDLE at cycle 4, no done within 10 cycles, result unchanged.
//     A new start at cycle 5 completes normally at cycle 11.
//  6. rst at cycle 2 of an op -> busy=0, done=0, result=0 next cycle. Back-to-back ops after done: 2000 random
//     operand/funct3 pairs vs a 64-bit reference model, with start issued the cycle after done.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared encodings for the iterative RV32M multiplier: funct3 op codes and FSM states.
package mul_unit_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        MU_IDLE = 2'b00,
        MU_CALC = 2'b01,
        MU_FIX  = 2'b10,
        MU_DONE = 2'b11
    } mu_state_e;

    // The low product half is only selected by MUL; all others return the high half.
    function automatic logic op_wants_high(input mul_op_e op);
        return op != OP_MUL;
    endfunction

endpackage

// File: rtl/mul_unit_operand_conv.sv
// Converts raw operands into unsigned magnitudes plus the product sign for the selected op.
module mul_operand_conv
    import mul_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  mul_op_e         op,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic sign_a;
    logic sign_b;

    assign sign_a = rs1[XLEN-1] & (op != OP_MULHU);
    assign sign_b = rs2[XLEN-1] & ((op == OP_MUL) || (op == OP_MULH));

    // Two's complement of the most negative value wraps to 2^(XLEN-1), which is the correct magnitude.
    assign mag_a = sign_a ? (~rs1 + ONE) : rs1;
    assign mag_b = sign_b ? (~rs2 + ONE) : rs2;
    assign neg   = sign_a ^ sign_b;

endmodule

// File: rtl/mul_unit.sv
// Multi-cycle radix-2^BITS_PER_CYCLE multiplier for MUL/MULH/MULHSU/MULHU with flush and fixed latency.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [2*XLEN-1:0] ONE_W = {{(2*XLEN-1){1'b0}}, 1'b1};

    mu_state_e             state_reg;
    mu_state_e             state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [2*XLEN-1:0]     mcand_reg;
    logic [XLEN-1:0]       mplier_reg;
    logic [2*XLEN-1:0]     acc_reg;
    logic                  neg_reg;
    mul_op_e               op_reg;
    logic [XLEN-1:0]       result_reg;

    mul_op_e               op_in;
    logic [XLEN-1:0]       conv_mag_a;
    logic [XLEN-1:0]       conv_mag_b;
    logic                  conv_neg;
    logic                  funct3_unused;

    logic [2*XLEN-1:0]     pp [BITS_PER_CYCLE];
    logic [2*XLEN-1:0]     step_sum;
    logic [2*XLEN-1:0]     acc_fixed;
    logic                  accept;

    assign op_in         = mul_op_e'(funct3[1:0]);
    assign funct3_unused = funct3[2];
    assign accept        = start && !flush;

    mul_operand_conv #(
        .XLEN (XLEN)
    ) u_conv (
        .rs1   (rs1_data),
        .rs2   (rs2_data),
        .op    (op_in),
        .mag_a (conv_mag_a),
        .mag_b (conv_mag_b),
        .neg   (conv_neg)
    );

    // One gated, pre-shifted partial product per multiplier bit of the current slice.
    // The multiplicand is shifted left each CALC cycle, so no variable shift is needed here.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
        assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    assign acc_fixed = neg_reg ? (~acc_reg + ONE_W) : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MU_IDLE: if (accept) state_next = MU_CALC;
            MU_CALC: begin
                if (flush)                                state_next = MU_IDLE;
                else if (cnt_reg == CNT_W'(ITER - 1))     state_next = MU_FIX;
            end
            MU_FIX:  state_next = flush ? MU_IDLE : MU_DONE;
            MU_DONE: state_next = MU_IDLE;
            default: state_next = MU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= MU_IDLE;
            cnt_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            op_reg     <= OP_MUL;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                MU_IDLE: begin
                    if (accept) begin
                        mcand_reg  <= {{XLEN{1'b0}}, conv_mag_a};
                        mplier_reg <= conv_mag_b;
                        neg_reg    <= conv_neg;
                        op_reg     <= op_in;
                        cnt_reg    <= '0;
                        acc_reg    <= '0;
                    end
                end
                MU_CALC: begin
                    acc_reg    <= acc_reg + step_sum;
                    mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                end
                MU_FIX: begin
                    // A flushed op must leave the previous result visible.
                    if (!flush) begin
                        result_reg <= op_wants_high(op_reg) ? acc_fixed[2*XLEN-1:XLEN]
                                                            : acc_fixed[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != MU_IDLE);
    assign done   = (state_reg == MU_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Directed and randomized checks of mul_unit: latency, sign handling, busy/start, flush and reset.
module tb_mul_unit;
    import mul_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;

    mul_unit #(.XLEN(32), .BITS_PER_CYCLE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        case (f3[1:0])
            2'b00, 2'b01: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; end
            2'b10:        begin ea = {{32{a[31]}}, a}; eb = {32'h0, b}; end
            default:      begin ea = {32'h0, a};       eb = {32'h0, b}; end
        endcase
        p = ea * eb;
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Caller is at cycle 0 (just after an edge); returns in the cycle done was seen.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit chk_busy);
        int done_at;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
        done_at = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (chk_busy && c <= 6) check({tag, "_busy"}, {63'h0, busy}, 64'h1);
            if (done) begin
                done_at = c;
                break;
            end
        end
        check({tag, "_lat"}, 64'(done_at), 64'd6);
        check({tag, "_res"}, {32'h0, result}, {32'h0, exp});
        $display("op %s f3=%0d a=%08h b=%08h result=%08h exp=%08h done_at=%0d",
                 tag, f3, a, b, result, exp, done_at);
    endtask

    initial begin
        int ndone;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1_data = '0; rs2_data = '0;
        repeat (3) tick();
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_result", {32'h0, result}, 64'h0);
        rst = 1'b0;
        tick();

        // 1: latency, busy window, done pulse width
        do_op("mul_7_m3", FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        tick();
        check("t1_done_after", {63'h0, done}, 64'h0);
        check("t1_busy_after", {63'h0, busy}, 64'h0);

        // 2/3: sign corner cases
        tick(); do_op("mulh_min", FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        tick(); do_op("mul_min", FUNCT3_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        tick(); do_op("mulhsu_ff", FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick(); do_op("mulhu_ff", FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        tick(); do_op("mulh_m1_1", FUNCT3_MULH, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        tick(); do_op("mul_f3b2", 3'b100, 32'd6, 32'd7, 32'd42, 1'b0);

        // 4: start pulses while busy are ignored
        tick();
        start = 1'b1; funct3 = FUNCT3_MUL; rs1_data = 32'd5; rs2_data = 32'd6;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = (c >= 2 && c <= 4);
            rs1_data = 32'd100; rs2_data = 32'd100;
            if (done) begin
                ndone++;
                check("t4_done_cyc", 64'(c), 64'd6);
                check("t4_result", {32'h0, result}, 64'd30);
            end
        end
        check("t4_ndone", 64'(ndone), 64'd1);
        $display("op busy_start ndone=%0d result=%08h", ndone, result);

        // 5: flush at cycle 3, restart at cycle 5
        start = 1'b1; funct3 = FUNCT3_MUL; rs1_data = 32'd9; rs2_data = 32'd9;
        ndone = 0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start = 1'b0;
            flush = (c == 3);
            if (c == 4) check("t5_idle", {63'h0, busy}, 64'h0);
            if (c == 5) begin
                start = 1'b1; funct3 = FUNCT3_MULHU; rs1_data = 32'h0001_0000; rs2_data = 32'h0001_0000;
            end
            if (c <= 10 && done) ndone++;
            if (c == 10) check("t5_res_kept", {32'h0, result}, 64'd30);
            if (c == 11) begin
                check("t5_done11", {63'h0, done}, 64'h1);
                check("t5_res_new", {32'h0, result}, 64'd1);
            end
        end
        check("t5_no_done", 64'(ndone), 64'd0);
        $display("op flush_restart ndone_before=%0d result=%08h", ndone, result);

        // 6: reset mid-operation
        tick();
        start = 1'b1; funct3 = FUNCT3_MUL; rs1_data = 32'd2; rs2_data = 32'd3;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            rst = (c == 2);
            if (c == 3) begin
                check("t6_busy", {63'h0, busy}, 64'h0);
                check("t6_done", {63'h0, done}, 64'h0);
                check("t6_result", {32'h0, result}, 64'h0);
            end
            if (c >= 3 && done) ndone++;
        end
        check("t6_no_done", 64'(ndone), 64'd0);
        $display("op rst_mid ndone=%0d result=%08h", ndone, result);

        // Back-to-back random ops, each start issued the cycle after the previous done
        tick();
        for (int n = 0; n < 2000; n++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h0;
                default: ;
            endcase
            do_op("rand", rf3, ra, rb, ref_mul(rf3, ra, rb), 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
